pc_flag_control: RTL and testbench

- Sequential control stage placed around the ALU in the single-cycle datapath.
- Consumes the ALU's per-cycle FLAG output and holds it in an architectural N/V/Z flag register.
- Returns the registered flags to the ALU FLAG_in input and drives the program counter.
- Evaluates the B (PC-relative) and BR (register) conditional branches against the registered flags; implements HLT as a sticky halt state.

---
 rtl/pc_flag_control.sv | 50 +++++
 tb/tb_pc_flag_control.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pc_flag_control.sv
// pc_flag_control: N/V/Z flag register, branch evaluation, PC sequencing and sticky halt around the ALU.
module pc_flag_control #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  alu_op,
  input  logic        alu_valid,
  input  logic [2:0]  alu_flag,
  input  logic        branch,
  input  logic        branch_reg,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state;
  logic n, v, z, cond_ok, wr_nv, wr_z;
  logic [7:0] cond_vec;
  logic [15:0] target, pc_next;
  assign {z, v, n} = flags;
  // indexed by cond: NE, EQ, GT, LT, GE, LE, OV, UN
  assign cond_vec = {1'b1, v, n | z, z | (~z & ~n), n, ~z & ~n, z, ~z};
  assign cond_ok = cond_vec[cond];
  assign pc_plus2 = pc + PC_STEP;
  assign branch_taken = (state == RUN) & ~halt & (branch | branch_reg) & cond_ok;
  assign target = branch_reg ? reg_target : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
  assign pc_next = halt ? pc : branch_taken ? target : pc_plus2;
  assign wr_nv = alu_valid & (alu_op == 3'b000 | alu_op == 3'b001);
  assign wr_z = wr_nv | (alu_valid & (alu_op == 3'b010 | alu_op == 3'b100 | alu_op == 3'b101 | alu_op == 3'b110));
  assign halted = (state == HALTED);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      flags <= 3'b000;
    end else if (state == RUN) begin
      state <= halt ? HALTED : RUN;
      pc <= pc_next;
      flags <= {wr_z ? alu_flag[2] : flags[2], wr_nv ? alu_flag[1:0] : flags[1:0]};
    end
  end
endmodule

// File: tb/tb_pc_flag_control.sv
// tb_pc_flag_control: scoreboard bench comparing pc_flag_control against a spec-level model.
module tb_pc_flag_control;
  logic clk = 0, rst = 1, alu_valid = 0, branch = 0, branch_reg = 0, halt = 0;
  logic [2:0] alu_op = 0, alu_flag = 0, cond = 0;
  logic [8:0] imm9 = 0;
  logic [15:0] reg_target = 0;
  logic [15:0] pc, pc_plus2;
  logic [2:0] flags;
  logic branch_taken, halted;
  int checks = 0, errors = 0;

  pc_flag_control dut (.clk(clk), .rst(rst), .alu_op(alu_op), .alu_valid(alu_valid), .alu_flag(alu_flag),
    .branch(branch), .branch_reg(branch_reg), .cond(cond), .imm9(imm9), .reg_target(reg_target), .halt(halt),
    .pc(pc), .pc_plus2(pc_plus2), .flags(flags), .branch_taken(branch_taken), .halted(halted));

  always #5 clk = ~clk;

  typedef struct {logic [15:0] pc, pp2; logic [2:0] fl; logic bt, h;} exp_t;
  exp_t q[$];

  int mpc = 0;
  logic [2:0] mfl = 0;
  bit mh = 0, known = 0;

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit n = f[0], v = f[1], z = f[2];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1;
    endcase
  endfunction

  task automatic step(input bit r, input bit av, input logic [2:0] op, input logic [2:0] af, input bit b,
                      input bit br, input logic [2:0] c, input logic [8:0] im, input logic [15:0] rt, input bit h);
    exp_t e;
    bit take;
    int off;
    @(posedge clk);
    #1;
    rst = r; alu_valid = av; alu_op = op; alu_flag = af; branch = b; branch_reg = br;
    cond = c; imm9 = im; reg_target = rt; halt = h;
    take = !mh && !h && (b || br) && cond_true(c, mfl);
    if (known) begin
      e.pc = mpc[15:0]; e.pp2 = 16'((mpc + 2) % 65536); e.fl = mfl; e.bt = take; e.h = mh;
      q.push_back(e);
    end
    if (r) begin
      mpc = 0; mfl = 0; mh = 0; known = 1;
    end else if (!mh) begin
      if (h) mh = 1;
      else begin
        off = im[8] ? int'(im) - 512 : int'(im);
        if (take) mpc = br ? int'(rt) : (mpc + 2 + 2 * off + 131072) % 65536;
        else mpc = (mpc + 2) % 65536;
        if (av && op <= 3'd1) mfl = af;
        else if (av && (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6)) mfl[2] = af[2];
      end
    end
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic alu(input logic [2:0] op, input logic [2:0] af); step(0, 1, op, af, 0, 0, 0, 0, 0, 0); endtask
  task automatic jump(input logic [15:0] a); step(0, 0, 0, 0, 0, 1, 3'd7, 0, a, 0); endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 5;
      if (pc !== e.pc) begin errors++; $display("FAIL pc got %h want %h at %0t", pc, e.pc, $time); end
      if (pc_plus2 !== e.pp2) begin errors++; $display("FAIL pc_plus2 got %h want %h at %0t", pc_plus2, e.pp2, $time); end
      if (flags !== e.fl) begin errors++; $display("FAIL flags got %b want %b at %0t", flags, e.fl, $time); end
      if (branch_taken !== e.bt) begin errors++; $display("FAIL branch_taken got %b want %b at %0t", branch_taken, e.bt, $time); end
      if (halted !== e.h) begin errors++; $display("FAIL halted got %b want %b at %0t", halted, e.h, $time); end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) idle();
    alu(3'd0, 3'b011);
    alu(3'd2, 3'b100);
    alu(3'd3, 3'b000);
    jump(16'h0010);
    step(0, 0, 0, 0, 1, 0, 3'd1, 9'h1FC, 0, 0);
    jump(16'h0010);
    step(0, 0, 0, 0, 1, 0, 3'd0, 9'h1FC, 0, 0);
    alu(3'd1, 3'b000);
    step(0, 1, 3'd1, 3'b100, 1, 0, 3'd1, 9'h004, 0, 0);
    step(0, 0, 0, 0, 1, 0, 3'd1, 9'h004, 0, 0);
    jump(16'hFFFE);
    step(0, 0, 0, 0, 0, 1, 3'd7, 0, 16'h1234, 0);
    jump(16'hFFFE);
    idle();
    jump(16'hFFFE);
    step(0, 0, 0, 0, 1, 0, 3'd7, 9'h002, 0, 0);
    jump(16'h0003);
    step(0, 0, 0, 0, 1, 1, 3'd7, 9'h005, 16'h0100, 0);
    jump(16'h0020);
    step(0, 0, 0, 0, 1, 0, 3'd7, 9'h010, 0, 1);
    alu(3'd0, 3'b111);
    step(0, 0, 0, 0, 1, 1, 3'd7, 9'h010, 16'h4444, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    repeat (3000) begin
      bit h;
      h = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 99) == 0, h ? 1'b0 : 1'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), $urandom_range(0, 3) == 0, 3'($urandom), 9'($urandom), 16'($urandom), h);
      if (mh && $urandom_range(0, 3) == 0) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1;
    rst = 0; alu_valid = 0; branch = 0; branch_reg = 0; halt = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
